// File: rtl/uart_tx_result_ctrl.sv
// Sends a latched 16-bit ALU result to a UART transmitter as two bytes, LSB first,
// with a settle delay before the first byte and a hold delay after each byte start.
module uart_tx_result_ctrl #(
    parameter int unsigned WAIT_FOR_REGISTER_DELAY = 100,
    parameter int unsigned INTER_BYTE_DELAY        = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic [15:0] result,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REGISTER  = 3'd1,
        S_SEND_LSB  = 3'd2,
        S_DELAY_LSB = 3'd3,
        S_SEND_MSB  = 3'd4,
        S_DELAY_MSB = 3'd5,
        S_DONE      = 3'd6,
        S_ILLEGAL   = 3'd7
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] result_q;
    logic [15:0] result_next;
    logic [31:0] hold_cnt;

    // True in the last cycle of a timed state lasting len cycles.
    function automatic logic expired(input logic [31:0] cnt, input int unsigned len);
        return (cnt + 32'd1) >= 32'(len);
    endfunction

    function automatic logic [7:0] byte_for(input state_t s, input logic [15:0] r);
        case (s)
            S_REGISTER, S_SEND_LSB, S_DELAY_LSB: return r[7:0];
            S_SEND_MSB, S_DELAY_MSB, S_DONE:     return r[15:8];
            default:                             return 8'h00;
        endcase
    endfunction

    // tx_start must react to tx_busy in the same cycle, so it cannot be registered;
    // gating with reset keeps an unstarted byte from leaving during a reset cycle.
    assign tx_start = !reset && !tx_busy && (state == S_SEND_LSB || state == S_SEND_MSB);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        result_next = result_q;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_next  = S_REGISTER;
                    result_next = result;
                end
            end
            S_REGISTER:  if (expired(hold_cnt, WAIT_FOR_REGISTER_DELAY)) state_next = S_SEND_LSB;
            S_SEND_LSB:  if (!tx_busy) state_next = S_DELAY_LSB;
            S_DELAY_LSB: if (expired(hold_cnt, INTER_BYTE_DELAY)) state_next = S_SEND_MSB;
            S_SEND_MSB:  if (!tx_busy) state_next = S_DELAY_MSB;
            S_DELAY_MSB: if (expired(hold_cnt, INTER_BYTE_DELAY)) state_next = S_DONE;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            result_q  <= '0;
            hold_cnt  <= '0;
            tx_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            state_dbg <= '0;
        end else begin
            state     <= state_next;
            result_q  <= result_next;
            hold_cnt  <= (state_next != state) ? 32'd0 : hold_cnt + 32'd1;
            // Outputs are decoded from the next state so they line up with the state register.
            tx_data   <= byte_for(state_next, result_next);
            busy      <= (state_next != S_IDLE);
            done      <= (state_next == S_DONE);
            state_dbg <= state_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_result_ctrl.sv
// Bench for uart_tx_result_ctrl: queue/countdown reference model checked every cycle,
// plus directed timing scenarios compared against expectation tables.
module tb_uart_tx_result_ctrl;

    localparam int W = 4;
    localparam int D = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trigger = 1'b0;
    logic [15:0] result = '0;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;
    logic [2:0]  state_dbg;

    uart_tx_result_ctrl #(
        .WAIT_FOR_REGISTER_DELAY(W),
        .INTER_BYTE_DELAY(D)
    ) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .result(result), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t0 = 0;

    // Reference model: a transfer is a queue of bytes still to send plus a wait countdown.
    logic       m_active = 1'b0;
    logic [7:0] m_q[$];
    logic [7:0] m_shown = 8'h00;
    int         m_wait = 0;

    // Per-scenario logs indexed by cycle relative to t0.
    logic       lg_start[64];
    logic [7:0] lg_data[64];
    logic       lg_done[64];
    logic       lg_busy[64];
    logic [2:0] lg_state[64];
    logic [7:0] sent_data[$];

    typedef struct {
        int         c;
        logic       start;
        logic [7:0] data;
        logic       dn;
        logic       bsy;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc - t0, act, exp);
        end
    endtask

    task automatic step(input logic trg, input logic [15:0] res, input logic txb, input logic rst);
        logic       e_start;
        logic [7:0] e_data;
        logic       e_done;
        int         rel;
        @(negedge clk);
        trigger = trg; result = res; tx_busy = txb; reset = rst;
        #1;
        e_start = !rst && m_active && m_wait == 0 && m_q.size() > 0 && !txb;
        e_done  = m_active && m_wait == 0 && m_q.size() == 0;
        if (!m_active)                          e_data = 8'h00;
        else if (m_wait == 0 && m_q.size() > 0) e_data = m_q[0];
        else                                    e_data = m_shown;
        check("model tx_start", 32'(tx_start), 32'(e_start));
        check("model tx_data", 32'(tx_data), 32'(e_data));
        check("model busy", 32'(busy), 32'(m_active));
        check("model done", 32'(done), 32'(e_done));
        check("model state_dbg idle", 32'(state_dbg == 3'd0), 32'(!m_active));
        rel = cyc - t0;
        if (rel >= 0 && rel < 64) begin
            lg_start[rel] = tx_start; lg_data[rel] = tx_data; lg_done[rel] = done;
            lg_busy[rel] = busy; lg_state[rel] = state_dbg;
        end
        if (tx_start) sent_data.push_back(tx_data);
        @(posedge clk);
        if (rst) begin
            m_active = 1'b0; m_q.delete(); m_shown = 8'h00; m_wait = 0;
        end else if (!m_active) begin
            if (trg) begin
                m_active = 1'b1; m_q = '{res[7:0], res[15:8]}; m_shown = res[7:0]; m_wait = W;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (m_q.size() > 0) begin
            if (!txb) begin
                m_shown = m_q.pop_front();
                m_wait = D;
            end
        end else begin
            m_active = 1'b0;
        end
        cyc++;
    endtask

    task automatic begin_scen();
        t0 = cyc;
        sent_data.delete();
        tbl.delete();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 1'b0, 1'b0);
    endtask

    task automatic check_table(input string name);
        foreach (tbl[i]) begin
            check({name, " start"}, 32'(lg_start[tbl[i].c]), 32'(tbl[i].start));
            check({name, " data"},  32'(lg_data[tbl[i].c]),  32'(tbl[i].data));
            check({name, " done"},  32'(lg_done[tbl[i].c]),  32'(tbl[i].dn));
            check({name, " busy"},  32'(lg_busy[tbl[i].c]),  32'(tbl[i].bsy));
        end
    endtask

    initial begin
        // Reset, with a trigger asserted alongside it that must be ignored.
        begin_scen();
        step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b1, 16'h1357, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check("reset state_dbg", 32'(lg_state[2]), 32'd0);
        check("reset busy", 32'(lg_busy[2]), 32'd0);
        check("reset tx_data", 32'(lg_data[2]), 32'd0);

        // Nominal transfer of A55A.
        begin_scen();
        step(1'b1, 16'hA55A, 1'b0, 1'b0);
        idle_steps(30);
        tbl.push_back('{0,  1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{1,  1'b0, 8'h5A, 1'b0, 1'b1});
        tbl.push_back('{4,  1'b0, 8'h5A, 1'b0, 1'b1});
        tbl.push_back('{5,  1'b1, 8'h5A, 1'b0, 1'b1});
        tbl.push_back('{6,  1'b0, 8'h5A, 1'b0, 1'b1});
        tbl.push_back('{15, 1'b0, 8'h5A, 1'b0, 1'b1});
        tbl.push_back('{16, 1'b1, 8'hA5, 1'b0, 1'b1});
        tbl.push_back('{17, 1'b0, 8'hA5, 1'b0, 1'b1});
        tbl.push_back('{26, 1'b0, 8'hA5, 1'b0, 1'b1});
        tbl.push_back('{27, 1'b0, 8'hA5, 1'b1, 1'b1});
        tbl.push_back('{28, 1'b0, 8'h00, 1'b0, 1'b0});
        check_table("nominal");
        check("nominal pulse count", 32'(sent_data.size()), 32'd2);

        // MSB start stalled by tx_busy for 7 cycles.
        begin_scen();
        step(1'b1, 16'hA55A, 1'b0, 1'b0);
        for (int c = 1; c < 40; c++) step(1'b0, 16'($urandom), (c >= 16 && c <= 22), 1'b0);
        for (int c = 16; c <= 23; c++) tbl.push_back('{c, (c == 23), 8'hA5, 1'b0, 1'b1});
        tbl.push_back('{33, 1'b0, 8'hA5, 1'b0, 1'b1});
        tbl.push_back('{34, 1'b0, 8'hA5, 1'b1, 1'b1});
        tbl.push_back('{35, 1'b0, 8'h00, 1'b0, 1'b0});
        check_table("stall");

        // Second trigger mid-transfer is ignored.
        begin_scen();
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        for (int c = 1; c < 32; c++) step(c == 8, (c == 8) ? 16'hFFFF : 16'h0, 1'b0, 1'b0);
        check("retrigger pulse count", 32'(sent_data.size()), 32'd2);
        if (sent_data.size() == 2) begin
            check("retrigger byte0", 32'(sent_data[0]), 32'h34);
            check("retrigger byte1", 32'(sent_data[1]), 32'h12);
        end

        // Reset during DELAY_LSB, with a trigger in the reset cycle.
        begin_scen();
        step(1'b1, 16'hABCD, 1'b0, 1'b0);
        for (int c = 1; c < 30; c++) step(c == 10, 16'h2222, 1'b0, c == 10);
        check("midreset state_dbg", 32'(lg_state[11]), 32'd0);
        check("midreset busy", 32'(lg_busy[11]), 32'd0);
        check("midreset pulse count", 32'(sent_data.size()), 32'd1);

        // Fresh 00FF transfer, trigger in DONE ignored, trigger in IDLE accepted.
        begin_scen();
        step(1'b1, 16'h00FF, 1'b0, 1'b0);
        for (int c = 1; c < 60; c++)
            step(c == 27 || c == 28, (c == 27) ? 16'h1111 : (c == 28) ? 16'hBEEF : 16'h0, 1'b0, 1'b0);
        tbl.push_back('{5,  1'b1, 8'hFF, 1'b0, 1'b1});
        tbl.push_back('{16, 1'b1, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{27, 1'b0, 8'h00, 1'b1, 1'b1});
        tbl.push_back('{28, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{33, 1'b1, 8'hEF, 1'b0, 1'b1});
        tbl.push_back('{44, 1'b1, 8'hBE, 1'b0, 1'b1});
        tbl.push_back('{55, 1'b0, 8'hBE, 1'b1, 1'b1});
        check_table("back2back");
        check("back2back pulse count", 32'(sent_data.size()), 32'd4);

        // Result input churning after acceptance.
        begin_scen();
        step(1'b1, 16'hC0DE, 1'b0, 1'b0);
        idle_steps(30);
        check("churn pulse count", 32'(sent_data.size()), 32'd2);
        if (sent_data.size() == 2) begin
            check("churn byte0", 32'(sent_data[0]), 32'hDE);
            check("churn byte1", 32'(sent_data[1]), 32'hC0);
        end

        // Random traffic against the model.
        begin_scen();
        t0 = -1000;
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 7) == 0, 16'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 199) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
